// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce and press/release strobes.
// Latency: columns captured 2 cycles after a row's dwell ends; key_valid/key_release 1 cycle after the debounced map updates.
// Backpressure: none; strobes are single-cycle pulses that the consumer must take when they occur.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rstn         synchronous reset, active-high (1 = reset)
//   key_col      column lines, active-low, asynchronous to clk
//   key_row      row drive, active-low, exactly one bit low
//   key_code     reported key index (row*4 + col), held while key_down
//   key_valid    one-cycle strobe on a debounced press
//   key_down     high while the reported press is held
//   key_release  one-cycle strobe when all keys are released after a press
module keypad_scan #(
  parameter int CLK_FREQ  = 50000000,
  parameter int SCAN_FREQ = 1000,
  parameter int DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       key_release
);

  localparam int SCAN_COUNT = CLK_FREQ / (SCAN_FREQ * 4) - 1;
  localparam int TW = (SCAN_COUNT > 0) ? $clog2(SCAN_COUNT + 1) : 1;
  localparam logic [TW-1:0] TERM = TW'(SCAN_COUNT);
  localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE);

  typedef enum logic {ST_IDLE, ST_PRESSED} state_t;

  logic [TW-1:0] timer_q;
  logic [1:0]    row_q;
  logic [3:0]    key_row_q;
  logic [3:0]    col_s1_q, col_s2_q;
  // Row index travels alongside the synchronizer so that the columns stored
  // for a row are the ones seen while that row was actually driven.
  logic          smp1_vld_q, smp2_vld_q;
  logic [1:0]    smp1_row_q, smp2_row_q;
  logic [15:0]   raw_map_q, prev_frame_q, deb_map_q;
  logic [3:0]    stable_cnt_q;
  state_t        state_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q, key_down_q, key_release_q;

  logic          tick;
  logic          frame_done;
  logic [15:0]   raw_map_d;
  logic [3:0]    stable_cnt_d;
  logic [3:0]    low_idx;

  assign tick       = (timer_q == TERM);
  assign frame_done = smp2_vld_q && (smp2_row_q == 2'd3);

  // Raw map including the row being captured this cycle.
  always_comb begin
    raw_map_d = raw_map_q;
    if (smp2_vld_q) begin
      raw_map_d[{smp2_row_q, 2'b00} +: 4] = ~col_s2_q;
    end
  end

  always_comb begin
    stable_cnt_d = 4'd0;
    if (raw_map_d == prev_frame_q) begin
      stable_cnt_d = (stable_cnt_q == 4'hF) ? 4'hF : stable_cnt_q + 4'd1;
    end
  end

  // Lowest set index of the debounced map (scan downwards so index 0 wins).
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (deb_map_q[i]) low_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      timer_q       <= '0;
      row_q         <= 2'd0;
      key_row_q     <= 4'b1110;
      col_s1_q      <= 4'd0;
      col_s2_q      <= 4'd0;
      smp1_vld_q    <= 1'b0;
      smp2_vld_q    <= 1'b0;
      smp1_row_q    <= 2'd0;
      smp2_row_q    <= 2'd0;
      raw_map_q     <= 16'd0;
      prev_frame_q  <= 16'd0;
      deb_map_q     <= 16'd0;
      stable_cnt_q  <= 4'd0;
      state_q       <= ST_IDLE;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_down_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      timer_q  <= tick ? '0 : timer_q + TW'(1);
      col_s1_q <= key_col;
      col_s2_q <= col_s1_q;

      smp1_vld_q <= tick;
      smp1_row_q <= row_q;
      smp2_vld_q <= smp1_vld_q;
      smp2_row_q <= smp1_row_q;

      if (tick) begin
        row_q     <= row_q + 2'd1;
        key_row_q <= {key_row_q[2:0], key_row_q[3]};
      end

      if (smp2_vld_q) begin
        raw_map_q <= raw_map_d;
      end

      if (frame_done) begin
        stable_cnt_q <= stable_cnt_d;
        prev_frame_q <= raw_map_d;
        // Update only on the frame where the run length first reaches the threshold.
        if (stable_cnt_d == DEB_CNT && stable_cnt_q != DEB_CNT) begin
          deb_map_q <= raw_map_d;
        end
      end

      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (deb_map_q != 16'd0) begin
            state_q     <= ST_PRESSED;
            key_code_q  <= low_idx;
            key_valid_q <= 1'b1;
            key_down_q  <= 1'b1;
          end
        end
        ST_PRESSED: begin
          // Code stays frozen; only a full release leaves this state.
          if (deb_map_q == 16'd0) begin
            state_q       <= ST_IDLE;
            key_release_q <= 1'b1;
            key_down_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key_row     = key_row_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad matrix model, frame-level reference model, directed and random scenarios.
// Latency: compares every cycle on the falling edge.
// Backpressure: none.
module tb_keypad_scan;

  localparam int CLK_FREQ  = 80;
  localparam int SCAN_FREQ = 10;
  localparam int DEB       = 2;
  localparam int DW        = CLK_FREQ / (SCAN_FREQ * 4);  // row dwell in cycles

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  key_col, key_row, key_code;
  logic        key_valid, key_down, key_release;
  logic [15:0] held;

  always #5 clk = ~clk;

  keypad_scan #(.CLK_FREQ(CLK_FREQ), .SCAN_FREQ(SCAN_FREQ), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rstn(rstn), .key_col(key_col), .key_row(key_row),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .key_release(key_release)
  );

  // Matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && key_row[r] == 1'b0) key_col[c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nrel   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int row; logic [3:0] cols; } smp_t;
  smp_t        pq[$];
  int          m_n, m_same;
  logic [15:0] m_raw, m_prev, m_deb;
  logic        m_down, m_valid, m_rel;
  logic [3:0]  m_code, m_row;

  function automatic logic [3:0] lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
    return 4'd0;
  endfunction

  // One clock edge: n counts edges since reset; a row's columns (as seen in the
  // last cycle of its dwell) land in the map two edges later.
  task automatic model_step();
    smp_t s;
    if (rstn) begin
      m_n = 0; m_raw = '0; m_prev = '0; m_deb = '0; m_same = 0;
      m_down = 0; m_code = '0; m_valid = 0; m_rel = 0;
      pq.delete();
    end else begin
      m_valid = 0; m_rel = 0;
      if (!m_down && m_deb != 0) begin
        m_down = 1; m_valid = 1; m_code = lowest(m_deb);
      end else if (m_down && m_deb == 0) begin
        m_down = 0; m_rel = 1;
      end
      if (pq.size() > 0 && pq[0].due == m_n) begin
        s = pq.pop_front();
        m_raw[s.row*4 +: 4] = s.cols;
        if (s.row == 3) begin
          if (m_raw == m_prev) m_same++; else m_same = 0;
          if (m_same == DEB) m_deb = m_raw;
          m_prev = m_raw;
        end
      end
      if (m_n % DW == DW - 1) pq.push_back('{m_n + 2, (m_n / DW) % 4, ~key_col});
      m_n++;
    end
    m_row = ~(4'b0001 << ((m_n / DW) % 4));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("key_row",     16'(key_row),     16'(m_row));
      chk("key_code",    16'(key_code),    16'(m_code));
      chk("key_valid",   16'(key_valid),   16'(m_valid));
      chk("key_down",    16'(key_down),    16'(m_down));
      chk("key_release", 16'(key_release), 16'(m_rel));
      if (key_valid === 1'b1) nvalid++;
      if (key_release === 1'b1) nrel++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_strobe(input bit rel, input int budget, input string name);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if ((rel ? key_release : key_valid) === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no strobe within %0d cycles, expected one", name, budget);
    end
  endtask

  logic [3:0] rot [10];
  int v0, r0;

  initial begin
    rot = '{4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE, 4'hE, 4'hD};
    held = '0;
    rstn = 1'b1;
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_key_row",     16'(key_row),     16'hE);
    chk("rst_key_code",    16'(key_code),    16'h0);
    chk("rst_key_valid",   16'(key_valid),   16'h0);
    chk("rst_key_down",    16'(key_down),    16'h0);
    chk("rst_key_release", 16'(key_release), 16'h0);

    rstn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("rotation_%0d", i), 16'(key_row), 16'(rot[i]));
    end
    step(40);

    // Single press of key (2,1) = 9
    v0 = nvalid; r0 = nrel;
    held = 16'(1) << 9;
    wait_strobe(1'b0, 32, "press9_valid");
    chk("press9_code", 16'(key_code), 16'd9);
    chk("press9_down", 16'(key_down), 16'd1);
    step(80);
    chk("press9_one_valid", 16'(nvalid - v0), 16'd1);
    chk("press9_no_release", 16'(nrel - r0), 16'd0);
    held = '0;
    wait_strobe(1'b1, 32, "release9");
    chk("release9_down", 16'(key_down), 16'd0);
    step(20);
    chk("release9_one", 16'(nrel - r0), 16'd1);

    // Bounce on key (0,3): differs every frame, then steady
    v0 = nvalid;
    for (int i = 0; i < 6; i++) begin
      held = held ^ (16'(1) << 3);
      step(8);
    end
    chk("bounce_no_valid", 16'(nvalid - v0), 16'd0);
    held = 16'(1) << 3;
    wait_strobe(1'b0, 32, "bounce_valid");
    chk("bounce_code", 16'(key_code), 16'd3);
    held = '0;
    wait_strobe(1'b1, 32, "bounce_release");
    step(10);

    // Multi-key: 12 and 5 together, lowest wins
    v0 = nvalid;
    held = (16'(1) << 12) | (16'(1) << 5);
    wait_strobe(1'b0, 40, "multi_valid");
    chk("multi_code", 16'(key_code), 16'd5);
    r0 = nrel;
    held = 16'(1) << 12;
    step(48);
    chk("multi_no_valid", 16'(nvalid - v0), 16'd1);
    chk("multi_no_release", 16'(nrel - r0), 16'd0);
    chk("multi_down_held", 16'(key_down), 16'd1);
    chk("multi_code_held", 16'(key_code), 16'd5);
    held = '0;
    wait_strobe(1'b1, 40, "multi_release");
    step(10);

    // Reset while key 7 is reported
    held = 16'(1) << 7;
    wait_strobe(1'b0, 32, "pre_reset_valid");
    chk("pre_reset_code", 16'(key_code), 16'd7);
    step(5);
    rstn = 1'b1;
    step(1);
    chk("midrst_down", 16'(key_down), 16'd0);
    chk("midrst_code", 16'(key_code), 16'd0);
    chk("midrst_row",  16'(key_row),  16'hE);
    rstn = 1'b0;
    v0 = nvalid;
    wait_strobe(1'b0, 32, "post_reset_valid");
    chk("post_reset_code", 16'(key_code), 16'd7);
    step(20);
    chk("post_reset_one_valid", 16'(nvalid - v0), 16'd1);
    held = '0;
    wait_strobe(1'b1, 32, "post_reset_release");

    // Random key sets, durations and occasional resets
    for (int it = 0; it < 40; it++) begin
      logic [15:0] h;
      int nk;
      h = '0;
      nk = $urandom_range(0, 2);
      for (int k = 0; k < nk; k++) h[$urandom_range(0, 15)] = 1'b1;
      held = h;
      if ($urandom_range(0, 9) == 0) begin
        rstn = 1'b1;
        step($urandom_range(1, 2));
        rstn = 1'b0;
      end
      step($urandom_range(4, 80));
    end
    held = '0;
    step(60);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix keypad scanner for the board's 4x4 key matrix. It is the input-side counterpart of the multiplexed 7-segment display driver: it drives one active-low row at a time on a timed rotation and samples the active-low column lines. It debounces complete scan frames and reports a single pressed key as a 4-bit code with one-cycle press/release strobes. It sits between the keypad pins and the application logic that consumes key events.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- SCAN_FREQ, 1000, full-frame scan rate in Hz (4 rows per frame)
- DEBOUNCE, 4, additional identical consecutive frames required before the debounced key map updates (range 1..15)
- SCAN_COUNT (derived, not overridable), CLK_FREQ/(SCAN_FREQ*4) - 1, row dwell terminal count
- clk  input  1  system clock, all logic on rising edge
- rstn  input  1  synchronous, active-high reset (asserted = 1, sampled on clk rising edge)
- key_col  input  4  column lines, active-low (0 = pressed key in the currently driven row), asynchronous to clk
- key_row  output  4  row drive, active-low, exactly one bit low at all times
- key_code  output  4  index of reported key = row*4 + col, held while key_down
- key_valid  output  1  one-cycle strobe on a debounced press
- key_down  output  1  level, high while the reported press is held
- key_release  output  1  one-cycle strobe when all keys are released after a press

## Operation
- key_col passes through a 2-flop synchronizer before any use.
- Dwell timer: counts 0..SCAN_COUNT, then wraps to 0. A tick occurs on the cycle where timer == SCAN_COUNT.
- On each tick:
  - store the inverted synchronized columns into raw_map[row*4 +: 4] for the current row (the row has been driven for a full dwell);
  - then advance the row 0→1→2→3→0. key_row = ~(1 << row).
- Frame complete = the tick that samples row 3. On frame complete:
  - compare the new raw_map with prev_frame;
  - if equal, stable_cnt saturates-increments; otherwise stable_cnt clears to 0;
  - prev_frame <= raw_map;
  - when stable_cnt transitions to DEBOUNCE, deb_map <= raw_map.
- Report FSM, evaluated each cycle on deb_map:
  - IDLE: if deb_map != 0, go to PRESSED. key_code <= lowest set index of deb_map; pulse key_valid; key_down <= 1.
  - PRESSED: key_code is frozen. Additional or changed keys never generate key_valid. If deb_map == 0, go to IDLE; pulse key_release; key_down <= 0.
- Multi-key: the lowest index wins at entry to PRESSED. Releasing the reported key while others remain held leaves the FSM in PRESSED.
- stable_cnt width is 4 bits and saturates at 15.

## Timing
- Reset values: key_row = 4'b1110, key_code = 0, key_valid = 0, key_down = 0, key_release = 0. Timer, row, raw_map, prev_frame, deb_map, stable_cnt and synchronizers are all 0. FSM = IDLE.
- Reset mid-operation: all of the above take effect on the first clk edge with rstn = 1, regardless of state. No strobes are issued because of reset.
- Row dwell = SCAN_COUNT+1 cycles. Frame = 4*(SCAN_COUNT+1) cycles.
- Column-to-sample latency: 2 cycles (synchronizer).
- Debounce latency: a press stable from frame N appears in deb_map at the frame-complete tick of frame N+DEBOUNCE. key_valid asserts on the following cycle. Release timing is symmetric.
- key_valid and key_release are exactly 1 cycle wide and never assert together. key_down rises and falls in the same cycle as the respective strobe.

## Test plan
All scenarios use CLK_FREQ=80, SCAN_FREQ=10, DEBOUNCE=2, giving SCAN_COUNT=1, dwell = 2 cycles and frame = 8 cycles. The bench models the matrix: key_col[c] = 0 when key (r,c) is held and key_row[r] = 0.
- Reset/rotation: hold rstn = 1 for 3 cycles, then release. Required: all outputs at reset values; key_row sequences 1110,1101,1011,0111,1110 changing every 2 cycles.
- Single press: hold key (2,1). Required: exactly one key_valid with key_code = 9 and key_down = 1, within 4 frames (32 cycles) of the press. Hold 10 frames: no further strobes. Release: one key_release within 4 frames, key_down = 0.
- Bounce: toggle key (0,3) so that it differs in alternate frames for 6 frames, then hold steady. Required: no key_valid during the bounce; one key_valid with key_code = 3 after steady.
- Multi-key: press keys 12 and 5 in the same frame. Required: key_code = 5. Release 5 and keep 12: no strobe, key_down stays 1, key_code stays 5. Release 12: one key_release.
- Reset mid-press: with key 7 reported, assert rstn = 1 for 1 cycle while the key stays held. Required: key_down = 0, key_code = 0 and key_row = 1110 on the next edge. Then exactly one new key_valid with key_code = 7 within 4 frames.
